inst_sram_slave: RTL
====================

// Module: inst_sram_slave
// PURPOSE
//  Responder end of the instruction-SRAM interface driven by the fetch stage:
//  en/we/addr/wdata in, rdata out exactly one cycle later. Backed by an
//  internal word array, byte-lane writes, a loader port for program preload,
//  and address-range checking. Sits between the CPU top and the SoC,
//  replacing the external inst RAM in unit benches and the FPGA build.
// PARAMETERS
//  ADDR_BASE   32'h1C00_0000  byte address mapped to word 0
//  DEPTH_LOG2  14             array depth = 2**DEPTH_LOG2 words (64 KB default)
//  OOR_DATA    32'h0340_0000  data returned for out-of-range reads (LA32 NOP)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  resetn           in   1   asynchronous active-low reset
//  inst_sram_en     in   1   access request this cycle
//  inst_sram_we     in   4   byte write enables, bit i -> wdata[8i+7:8i]
//  inst_sram_addr   in   32  byte address; addr[1:0] ignored
//  inst_sram_wdata  in   32  write data
//  inst_sram_rdata  out  32  read data, valid cycle after en
//  ld_en            in   1   loader write strobe (full word)
//  ld_idx           in   DEPTH_LOG2  loader word index
//  ld_data          in   32  loader write data
//  oor_err          out  1   registered pulse: previous en access was out of range
//  oor_seen         out  1   sticky: any out-of-range access since reset
// BEHAVIOUR
//  - Reset (resetn=0, async): rdata=0, oor_err=0, oor_seen=0. Array contents
//    NOT reset; they survive reset and loader writes during reset are taken.
//  - Decode: off = addr - ADDR_BASE (32-bit wrap). In range iff
//    off < 4*2**DEPTH_LOG2 (unsigned). Word index = off[DEPTH_LOG2+1:2].
//  - Read: every cycle with en=1, rdata <= in range ? array[idx] : OOR_DATA
//    (full word, regardless of we). Latency exactly 1 cycle, no stall.
//  - Hold: en=0 -> rdata holds its last value indefinitely; the fetch stage
//    relies on this while stalled (it drops en but keeps consuming rdata).
//  - Write: en=1 and in range -> bytes with we[i]=1 updated at the edge.
//    we=0 is a pure read. Out-of-range writes are dropped.
//  - Read/write same word, same cycle: read-first; rdata returns the OLD
//    word; the new value is visible to a read in the following cycle.
//  - Loader: ld_en=1 writes ld_data to array[ld_idx], all four bytes, in
//    any reset state. Same word also written by core in same cycle: loader
//    wins for all bytes. Different words: both writes occur.
//    Loader does not affect rdata in the same cycle (read-first applies).
//  - oor_err <= en & ~in_range each cycle (1-cycle pulse aligned with
//    rdata); oor_seen <= oor_seen | (en & ~in_range); clears only on reset.
//  - Misaligned addr: low bits ignored silently; no error (fetch raises ADEF).
//  - Reset asserted mid-access: rdata forced to 0 immediately; any write
//    sampled on an edge while resetn=0 is discarded (loader excepted).
//  - Array may be initialised via $readmemh when a non-empty init file is
//    supplied by the build; otherwise contents are X until written.
// TESTING
//  1 Reset: resetn=0 then 1 -> rdata=0, oor_err=0, oor_seen=0 before any en.
//  2 Preload: ld idx0=32'h0280_0421, en=1 addr=1C00_0000 -> next cycle
//    rdata=32'h0280_0421; addr 1C00_0003 returns same word.
//  3 Hold: read idx0, then en=0 for 5 cycles while loader rewrites idx0 ->
//    rdata stays 32'h0280_0421 all 5 cycles; next en read returns new value.
//  4 Byte write: word=32'h1122_3344, en=1 we=4'b0101 wdata=AABB_CCDD ->
//    rdata that cycle+1 = 1122_3344 (read-first); next read = 11BB_33DD.
//  5 Range: en=1 addr=1C01_0000 (DEPTH_LOG2=14) -> rdata=0340_0000,
//    oor_err=1 for one cycle, oor_seen stays 1; write there leaves array
//    unchanged; addr=1BFF_FFFC also out of range.
//  6 Collision: core we=4'hF data=DEAD_BEEF and ld data=CAFE_F00D same
//    word same cycle -> later read returns CAFE_F00D; reset pulse mid-burst
//    -> rdata 0 asynchronously, array intact afterwards.

Source files
------------

// File: rtl/inst_sram_slave_if.sv
// rtl/inst_sram_slave_if.sv - instruction-SRAM request/response bundle between fetch stage and SRAM
interface inst_sram_slave_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

// File: rtl/inst_sram_slave.sv
// rtl/inst_sram_slave.sv - instruction-SRAM responder: 1-cycle read, byte-lane writes, loader port, range check
module inst_sram_slave #(
    parameter logic [31:0] ADDR_BASE  = 32'h1C00_0000,
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] OOR_DATA   = 32'h0340_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    inst_sram_slave_if.slave      bus,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [31:0]           ld_data,
    output logic                  oor_err,
    output logic                  oor_seen
);
    localparam int          DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(4) << DEPTH_LOG2;

    logic [31:0]           mem [0:DEPTH-1];
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  core_wr;

    // Offset wraps at 32 bits, so addresses below the base land far out of range.
    assign off      = bus.inst_sram_addr - ADDR_BASE;
    assign in_range = {1'b0, off} < SPAN;
    assign idx      = off[DEPTH_LOG2+1:2];
    assign core_wr  = resetn & bus.inst_sram_en & in_range;

    // Storage has no reset; the loader statement comes last so it owns a shared word.
    always_ff @(posedge clk) begin
        if (core_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.inst_sram_we[i]) begin
                    mem[idx][8*i +: 8] <= bus.inst_sram_wdata[8*i +: 8];
                end
            end
        end
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Read-first: rdata samples the array before this edge's writes land.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.inst_sram_rdata <= 32'h0;
            oor_err             <= 1'b0;
            oor_seen            <= 1'b0;
        end else begin
            oor_err <= bus.inst_sram_en & ~in_range;
            if (bus.inst_sram_en) begin
                bus.inst_sram_rdata <= in_range ? mem[idx] : OOR_DATA;
                if (!in_range) begin
                    oor_seen <= 1'b1;
                end
            end
        end
    end
endmodule
